vga_scene_ctrl: RTL and testbench



---
 rtl/vga_scene_ctrl_if.sv | 21 ++
 rtl/vga_scene_ctrl.sv | 125 ++++++++++++
 tb/tb_vga_scene_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_scene_ctrl_if.sv
// Picture-sequencer bus: frame/button/auto controls in, sprite offsets and scene flags out.
interface vga_scene_ctrl_if;
  logic        frame_start;
  logic        btn_mode;
  logic        auto_en;
  logic [11:0] hpos;
  logic [11:0] vpos;
  logic        v2_show_en;
  logic        disp_en;
  logic [1:0]  scene_state;

  modport master (
    output frame_start, btn_mode, auto_en,
    input  hpos, vpos, v2_show_en, disp_en, scene_state
  );

  modport slave (
    input  frame_start, btn_mode, auto_en,
    output hpos, vpos, v2_show_en, disp_en, scene_state
  );
endinterface

// File: rtl/vga_scene_ctrl.sv
// Scene sequencer for the VGA datapath: bouncing sprite animation, scene switching
// on button or dwell timeout, and blanked frames across every scene change.
module vga_scene_ctrl #(
  parameter int H_MAX        = 505,
  parameter int V_MAX        = 345,
  parameter int STEP         = 2,
  parameter int DWELL_FRAMES = 600,
  parameter int BLANK_FRAMES = 4
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  vga_scene_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ANIM    = 2'd0,
    TO_INFO = 2'd1,
    INFO    = 2'd2,
    TO_ANIM = 2'd3
  } state_t;

  localparam int DCW = $clog2(DWELL_FRAMES + 1);
  localparam int BCW = $clog2(BLANK_FRAMES + 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_FRAMES - 1);
  localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_FRAMES - 1);

  state_t         state, state_nxt;
  logic [DCW-1:0] dwell_cnt, dwell_nxt;
  logic [BCW-1:0] blank_cnt, blank_nxt;
  logic [11:0]    hpos_q, hpos_nxt, vpos_q, vpos_nxt;
  logic           dir_x, dir_x_nxt, dir_y, dir_y_nxt;
  logic           v2_q, disp_q;
  logic [1:0]     scene_q;
  logic           trigger;
  logic [12:0]    h_res, v_res;

  // One axis of the bounce, done at 13 bits; result is {new_dir, new_pos}.
  function automatic logic [12:0] axis_step(input logic [11:0] pos, input logic dir_pos,
                                            input logic [12:0] lim);
    logic [12:0] wide;
    wide = {1'b0, pos};
    if (dir_pos) begin
      if (wide + 13'(STEP) >= lim) axis_step = {1'b0, lim[11:0]};
      else                         axis_step = {1'b1, 12'(wide + 13'(STEP))};
    end else begin
      if (wide <= 13'(STEP)) axis_step = {1'b1, 12'd0};
      else                   axis_step = {1'b0, 12'(wide - 13'(STEP))};
    end
  endfunction

  assign trigger = bus.btn_mode || (bus.auto_en && bus.frame_start && dwell_cnt == DWELL_LAST);
  assign h_res   = axis_step(hpos_q, dir_x, 13'(H_MAX));
  assign v_res   = axis_step(vpos_q, dir_y, 13'(V_MAX));

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    blank_nxt = blank_cnt;
    hpos_nxt  = hpos_q;
    vpos_nxt  = vpos_q;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    case (state)
      ANIM, INFO: begin
        if (trigger)
          state_nxt = (state == ANIM) ? TO_INFO : TO_ANIM;
        else if (bus.frame_start && dwell_cnt != DWELL_LAST)
          dwell_nxt = dwell_cnt + DCW'(1);
      end
      TO_INFO, TO_ANIM: begin
        if (bus.frame_start) begin
          if (blank_cnt == BLANK_LAST)
            state_nxt = (state == TO_INFO) ? INFO : ANIM;
          else
            blank_nxt = blank_cnt + BCW'(1);
        end
      end
      default: state_nxt = ANIM;
    endcase
    if (state_nxt != state) begin
      dwell_nxt = '0;
      blank_nxt = '0;
    end
    // The sprite still takes its step on the frame that leaves ANIM.
    if (bus.frame_start && state == ANIM) begin
      dir_x_nxt = h_res[12];
      hpos_nxt  = h_res[11:0];
      dir_y_nxt = v_res[12];
      vpos_nxt  = v_res[11:0];
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ANIM;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      v2_q      <= 1'b0;
      disp_q    <= 1'b1;
      scene_q   <= 2'd0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      blank_cnt <= blank_nxt;
      hpos_q    <= hpos_nxt;
      vpos_q    <= vpos_nxt;
      dir_x     <= dir_x_nxt;
      dir_y     <= dir_y_nxt;
      v2_q      <= (state_nxt == INFO) || (state_nxt == TO_ANIM);
      disp_q    <= (state_nxt == ANIM) || (state_nxt == INFO);
      scene_q   <= state_nxt;
    end
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.v2_show_en  = v2_q;
  assign bus.disp_en     = disp_q;
  assign bus.scene_state = scene_q;

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Self-checking bench for vga_scene_ctrl: directed scenarios plus random traffic
// compared against a scene/position reference model.
module tb_vga_scene_ctrl;

  localparam int H_MAX = 10;
  localparam int V_MAX = 6;
  localparam int STEP  = 2;
  localparam int DWELL = 5;
  localparam int BLANK = 2;

  logic clk_25MHz = 1'b0;
  logic rst_n     = 1'b0;

  vga_scene_ctrl_if bus ();

  vga_scene_ctrl #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .STEP(STEP),
    .DWELL_FRAMES(DWELL), .BLANK_FRAMES(BLANK)
  ) dut (
    .clk_25MHz(clk_25MHz),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which content is on screen, whether we are blanking,
  // and how many frames have elapsed in the current phase.
  int m_hpos, m_vpos, m_scene, m_frames, m_blank_seen;
  bit m_dx, m_dy, m_blank;

  int exp_h[8] = '{2, 4, 6, 8, 10, 8, 6, 4};
  int exp_v[8] = '{2, 4, 6, 4, 2, 0, 2, 4};

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_hpos = 0; m_vpos = 0; m_dx = 1; m_dy = 1;
    m_scene = 0; m_blank = 0; m_frames = 0; m_blank_seen = 0;
  endtask

  task automatic bounce(inout int pos, inout bit up, input int lim);
    if (up) begin
      pos = (pos + STEP < lim) ? pos + STEP : lim;
      if (pos == lim) up = 0;
    end else begin
      pos = (pos > STEP) ? pos - STEP : 0;
      if (pos == 0) up = 1;
    end
  endtask

  task automatic modelStep(input bit fs, input bit btn, input bit auto);
    if (!m_blank) begin
      if (fs && m_scene == 0) begin
        bounce(m_hpos, m_dx, H_MAX);
        bounce(m_vpos, m_dy, V_MAX);
      end
      if (btn || (auto && fs && m_frames >= DWELL - 1)) begin
        m_blank = 1; m_blank_seen = 0; m_frames = 0;
      end else if (fs) begin
        m_frames++;
      end
    end else if (fs) begin
      if (m_blank_seen == BLANK - 1) begin
        m_blank = 0; m_scene ^= 1; m_frames = 0; m_blank_seen = 0;
      end else begin
        m_blank_seen++;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("hpos", int'(bus.hpos), m_hpos);
    checkOutput("vpos", int'(bus.vpos), m_vpos);
    checkOutput("v2_show_en", int'(bus.v2_show_en), m_scene);
    checkOutput("disp_en", int'(bus.disp_en), m_blank ? 0 : 1);
    checkOutput("scene_state", int'(bus.scene_state),
                m_blank ? (m_scene ? 3 : 1) : (m_scene ? 2 : 0));
  endtask

  task automatic applyStimulus(input bit fs, input bit btn, input bit auto);
    @(negedge clk_25MHz);
    bus.frame_start = fs;
    bus.btn_mode    = btn;
    bus.auto_en     = auto;
    @(posedge clk_25MHz);
    modelStep(fs, btn, auto);
    #1;
    checkAll();
  endtask

  // A frame pulse followed by two quiet cycles.
  task automatic frame(input bit btn, input bit auto);
    applyStimulus(1'b1, btn, auto);
    applyStimulus(1'b0, 1'b0, auto);
    applyStimulus(1'b0, 1'b0, auto);
  endtask

  task automatic doReset();
    @(negedge clk_25MHz);
    bus.frame_start = 0; bus.btn_mode = 0; bus.auto_en = 0;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_scene", int'(bus.scene_state), 0);
    checkOutput("rst_hpos", int'(bus.hpos), 0);
    checkOutput("rst_vpos", int'(bus.vpos), 0);
    checkOutput("rst_disp", int'(bus.disp_en), 1);
    checkOutput("rst_v2", int'(bus.v2_show_en), 0);
    @(negedge clk_25MHz);
    rst_n = 1'b1;
  endtask

  initial begin
    bit auto_r;
    bus.frame_start = 0; bus.btn_mode = 0; bus.auto_en = 0;
    modelReset();
    repeat (2) @(posedge clk_25MHz);
    doReset();

    // Bounce sequence with fixed expected offsets.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("bounce_h", int'(bus.hpos), exp_h[i]);
      checkOutput("bounce_v", int'(bus.vpos), exp_v[i]);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end

    // Button into the info scene, then auto rotation back.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("btn_to_info", int'(bus.scene_state), 1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    checkOutput("info_reached", int'(bus.scene_state), 2);
    checkOutput("info_hold_h", int'(bus.hpos), 4);
    for (int i = 0; i < DWELL; i++) frame(1'b0, 1'b1);
    checkOutput("auto_to_anim", int'(bus.scene_state), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("anim_reached", int'(bus.scene_state), 0);

    // Button coincident with dwell expiry: a single transition.
    for (int i = 0; i < DWELL - 1; i++) frame(1'b0, 1'b1);
    frame(1'b1, 1'b1);
    checkOutput("coincident", int'(bus.scene_state), 1);

    // Reset while blanking.
    frame(1'b0, 1'b0);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Random traffic.
    auto_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) auto_r = ~auto_r;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, auto_r);
      if ($urandom_range(0, 1499) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
